serial_alu_seq: RTL and testbench
=================================

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/accumulator length in bits (count of serial bit-cycles per operation).
REQ-002 SHALL have port i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request operation; sampled only in IDLE.
REQ-005 SHALL have port i_op  input  3  opcode (see REQ-012); latched with i_start.
REQ-006 SHALL have port i_acc_bit  input  1  accumulator serial output (current LSB, operand A).
REQ-007 SHALL have port i_mem_bit  input  1  operand B serial bit, LSB-first, valid while o_busy=1.
REQ-008 SHALL have port o_con_shift, o_con_write  output  1 each  accumulator shift/write controls.
REQ-009 SHALL have port o_result_bit  output  1  serial result bit into accumulator data input.
REQ-010 SHALL have ports o_busy, o_done  output  1 each  operation in progress / one-cycle completion pulse.
REQ-011 SHALL have ports o_carry, o_zero  output  1 each  registered flags of last completed operation.

Function
REQ-012 Opcodes SHALL be: 0 ADD (A+B), 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 LOAD (B), 6 CLR (0); 7 SHALL act as no-op (NOP).
REQ-013 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE->RUN when i_start=1 and i_op!=7; i_start with i_op=7 SHALL go IDLE->DONE directly, flags unchanged.
REQ-015 On IDLE->RUN: latch i_op, clear bit counter to 0, load carry register with 1 for SUB, else 0.
REQ-016 RUN SHALL last exactly WIDTH cycles; counter increments each RUN cycle; counter==WIDTH-1 transitions RUN->DONE.
REQ-017 In RUN: o_con_shift=1; o_con_write=1 for all ops except CLR (o_con_write=0, accumulator zero-fills).
REQ-018 In RUN o_result_bit SHALL be combinational from i_acc_bit, i_mem_bit (inverted for SUB), carry register and latched op; 0 outside RUN.
REQ-019 ADD/SUB: sum = A^B'^c; carry register <= majority(A,B',c) each RUN cycle.
REQ-020 Zero tracker SHALL clear on RUN entry and OR in each result bit; o_zero <= ~tracker on RUN->DONE.
REQ-021 o_carry SHALL update on RUN->DONE: final carry for ADD/SUB (SUB: 1 = no borrow), 0 for logic/LOAD/CLR.
REQ-022 DONE SHALL last one cycle with o_done=1, then return to IDLE; o_busy=1 in RUN only.
REQ-023 i_start during RUN or DONE SHALL be ignored (no queuing); i_op changes after start SHALL not affect the operation.
REQ-024 Outside RUN, o_con_shift and o_con_write SHALL be 0 so the accumulator holds.
REQ-025 Latency start-to-o_done SHALL be WIDTH+1 cycles after the i_start sampling edge.

Reset
REQ-026 i_rst SHALL force IDLE, counter 0, carry register 0, tracker 0, o_carry=0, o_zero=0, o_done=0, o_busy=0, controls 0, immediately, including mid-RUN.
REQ-027 Reset mid-RUN SHALL abort without o_done; accumulator content is then undefined by this block.

Structure
REQ-028 Shared package SHALL hold opcode enum (op_t) and FSM state enum; WIDTH default constant lives there.
REQ-029 One sub-module SHALL be natural: serial_full_adder (combinational sum/carry-out for one bit); carry FF stays in parent.

Verification (WIDTH=8, accumulator model attached)
REQ-030 Acc=0x35, B=0x4A, ADD -> acc=0x7F, o_carry=0, o_zero=0, o_done exactly 9 cycles after start edge.
REQ-031 Acc=0xFF, B=0x01, ADD -> acc=0x00, o_carry=1, o_zero=1.
REQ-032 Acc=0x10, B=0x10, SUB -> acc=0x00, o_carry=1, o_zero=1; Acc=0x05, B=0x07, SUB -> acc=0xFE, o_carry=0.
REQ-033 Acc=0xF0, B=0x3C: AND->0x30, OR->0xFC, XOR->0xCC, LOAD->0x3C, CLR->0x00 with o_con_write=0 throughout RUN.
REQ-034 Assert i_rst at RUN cycle 4 -> all outputs 0 next evaluation, no o_done; subsequent ADD completes normally.
REQ-035 i_start pulsed during RUN and i_op=7 in IDLE -> ignored and single-cycle DONE respectively, flags unchanged.

Source files
------------

// File: rtl/serial_alu_seq_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcodes, FSM states and the
// default operand width.
package serial_alu_seq_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_LOAD = 3'd5,
    OP_CLR  = 3'd6,
    OP_NOP  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// Control/data bundle between the serial ALU sequencer and its accumulator and
// requester. slave is the ALU side, master the environment side.
interface serial_alu_seq_if;
  logic       i_start;
  logic [2:0] i_op;
  logic       i_acc_bit;
  logic       i_mem_bit;
  logic       o_con_shift;
  logic       o_con_write;
  logic       o_result_bit;
  logic       o_busy;
  logic       o_done;
  logic       o_carry;
  logic       o_zero;

  modport slave (
    input  i_start, i_op, i_acc_bit, i_mem_bit,
    output o_con_shift, o_con_write, o_result_bit, o_busy, o_done, o_carry, o_zero
  );

  modport master (
    output i_start, i_op, i_acc_bit, i_mem_bit,
    input  o_con_shift, o_con_write, o_result_bit, o_busy, o_done, o_carry, o_zero
  );
endinterface

// File: rtl/serial_full_adder.sv
// One-bit full adder; the carry state is held by the caller.
module serial_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: streams WIDTH LSB-first bits of accumulator and
// operand through one full adder / logic slice, writing results back serially.
module serial_alu_seq
  import serial_alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  serial_alu_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        state_r;
  op_t           op_r;
  logic [CW-1:0] cnt_r;
  logic          carry_r;
  logic          zero_trk_r;
  logic          con_shift_r;
  logic          con_write_r;
  logic          busy_r;
  logic          done_r;
  logic          carry_flag_r;
  logic          zero_flag_r;

  logic          b_eff_s;
  logic          sum_s;
  logic          cout_s;
  logic          slice_s;
  logic          result_bit_s;

  serial_full_adder u_fa (
    .a    (bus.i_acc_bit),
    .b    (b_eff_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Per-bit result slice; operand B is inverted for SUB (A + ~B + 1).
  always_comb begin
    b_eff_s = bus.i_mem_bit ^ (op_r == OP_SUB);
    case (op_r)
      OP_ADD, OP_SUB: slice_s = sum_s;
      OP_AND:         slice_s = bus.i_acc_bit & b_eff_s;
      OP_OR:          slice_s = bus.i_acc_bit | b_eff_s;
      OP_XOR:         slice_s = bus.i_acc_bit ^ b_eff_s;
      OP_LOAD:        slice_s = b_eff_s;
      default:        slice_s = 1'b0;
    endcase
    if (state_r == ST_RUN) begin
      result_bit_s = slice_s;
    end else begin
      result_bit_s = 1'b0;
    end
  end

  // Sequencer FSM with registered controls and flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_ADD;
      cnt_r        <= '0;
      carry_r      <= 1'b0;
      zero_trk_r   <= 1'b0;
      con_shift_r  <= 1'b0;
      con_write_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      carry_flag_r <= 1'b0;
      zero_flag_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.i_start) begin
            if (op_t'(bus.i_op) == OP_NOP) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= ST_RUN;
              op_r        <= op_t'(bus.i_op);
              cnt_r       <= '0;
              carry_r     <= (op_t'(bus.i_op) == OP_SUB);
              zero_trk_r  <= 1'b0;
              busy_r      <= 1'b1;
              con_shift_r <= 1'b1;
              con_write_r <= (op_t'(bus.i_op) != OP_CLR);
            end
          end
        end
        ST_RUN: begin
          cnt_r      <= cnt_r + CW'(1);
          zero_trk_r <= zero_trk_r | result_bit_s;
          if (op_is_arith(op_r)) begin
            carry_r <= cout_s;
          end
          if (cnt_r == CNT_LAST) begin
            state_r      <= ST_DONE;
            busy_r       <= 1'b0;
            con_shift_r  <= 1'b0;
            con_write_r  <= 1'b0;
            done_r       <= 1'b1;
            carry_flag_r <= op_is_arith(op_r) ? cout_s : 1'b0;
            zero_flag_r  <= ~(zero_trk_r | result_bit_s);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          con_shift_r <= 1'b0;
          con_write_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_con_shift  = con_shift_r;
  assign bus.o_con_write  = con_write_r;
  assign bus.o_result_bit = result_bit_s;
  assign bus.o_busy       = busy_r;
  assign bus.o_done       = done_r;
  assign bus.o_carry      = carry_flag_r;
  assign bus.o_zero       = zero_flag_r;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with an 8-bit shifting accumulator and
// operand register attached.
module tb_serial_alu_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  serial_alu_seq_if bus ();

  serial_alu_seq #(.WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] acc_m;
  logic [7:0] mem_m;
  logic       load_en;
  logic [7:0] load_acc;
  logic [7:0] load_mem;

  // Accumulator: shifts right, result bit enters at the MSB.
  always @(posedge clk) begin
    if (load_en) begin
      acc_m <= load_acc;
      mem_m <= load_mem;
    end else if (bus.o_con_shift) begin
      acc_m <= {bus.o_result_bit & bus.o_con_write, acc_m[7:1]};
      mem_m <= {1'b0, mem_m[7:1]};
    end
  end

  assign bus.i_acc_bit = acc_m[0];
  assign bus.i_mem_bit = mem_m[0];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    load_en  = 1'b1;
    load_acc = a;
    load_mem = b;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Starts an op and waits (bounded) until o_done, counting cycles from the sampling edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input bit pulse, output int cyc, output logic wr_seen);
    load(a, b);
    bus.i_op    = op;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_op    = 3'd7;
    cyc     = 1;
    wr_seen = 1'b0;
    while (bus.o_done !== 1'b1 && cyc < 40) begin
      if (bus.o_busy && bus.o_con_write) wr_seen = 1'b1;
      if (pulse && cyc == 3) begin
        bus.i_start = 1'b1;
        bus.i_op    = 3'd6;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_start = 1'b0;
  endtask

  int   cyc;
  logic wr;
  int   done_cnt;

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    load_en     = 1'b0;
    load_acc    = 8'h00;
    load_mem    = 8'h00;
    bus.i_start = 1'b0;
    bus.i_op    = 3'd0;
    rst         = 1'b1;
    #12;
    check("rst_busy",  {7'd0, bus.o_busy},      8'h00);
    check("rst_done",  {7'd0, bus.o_done},      8'h00);
    check("rst_shift", {7'd0, bus.o_con_shift}, 8'h00);
    check("rst_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h35, 8'h4A, 3'd0, 1'b0, cyc, wr);
    check("add1_lat",   8'(cyc), 8'd9);
    check("add1_acc",   acc_m, 8'h7F);
    check("add1_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h00);
    check("add1_wr",    {7'd0, wr}, 8'h01);
    @(negedge clk);
    check("add1_done1", {7'd0, bus.o_done}, 8'h00);

    run_op(8'hFF, 8'h01, 3'd0, 1'b0, cyc, wr);
    check("add2_acc",   acc_m, 8'h00);
    check("add2_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h03);

    run_op(8'hF0, 8'h3C, 3'd2, 1'b0, cyc, wr);
    check("and_acc",   acc_m, 8'h30);
    check("and_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h00);
    run_op(8'hF0, 8'h3C, 3'd3, 1'b0, cyc, wr);
    check("or_acc",    acc_m, 8'hFC);
    run_op(8'hF0, 8'h3C, 3'd4, 1'b0, cyc, wr);
    check("xor_acc",   acc_m, 8'hCC);
    run_op(8'hF0, 8'h3C, 3'd5, 1'b0, cyc, wr);
    check("load_acc",  acc_m, 8'h3C);
    run_op(8'hF0, 8'h3C, 3'd6, 1'b0, cyc, wr);
    check("clr_acc",   acc_m, 8'h00);
    check("clr_wr",    {7'd0, wr}, 8'h00);
    check("clr_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h01);

    run_op(8'h10, 8'h10, 3'd1, 1'b0, cyc, wr);
    check("sub1_acc",   acc_m, 8'h00);
    check("sub1_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h03);

    // NOP: straight to a one-cycle DONE, accumulator and flags untouched.
    @(negedge clk);
    bus.i_op    = 3'd7;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("nop_done",  {7'd0, bus.o_done}, 8'h01);
    check("nop_busy",  {6'd0, bus.o_busy, bus.o_con_shift}, 8'h00);
    check("nop_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h03);
    @(negedge clk);
    check("nop_done1", {7'd0, bus.o_done}, 8'h00);
    check("nop_acc",   acc_m, 8'h00);

    // Reset during the fourth RUN cycle.
    load(8'h35, 8'h4A);
    bus.i_op    = 3'd0;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_ctl",   {5'd0, bus.o_busy, bus.o_con_shift, bus.o_con_write}, 8'h00);
    check("mrst_out",   {5'd0, bus.o_result_bit, bus.o_done, 1'b0}, 8'h00);
    check("mrst_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) done_cnt++;
    end
    check("mrst_nodone", 8'(done_cnt), 8'd0);

    // Borrow case with a start pulse mid-RUN that must be ignored.
    run_op(8'h05, 8'h07, 3'd1, 1'b1, cyc, wr);
    check("sub2_lat",   8'(cyc), 8'd9);
    check("sub2_acc",   acc_m, 8'hFE);
    check("sub2_flags", {6'd0, bus.o_carry, bus.o_zero}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("sub2_idle",  {6'd0, bus.o_busy, bus.o_done}, 8'h00);

    run_op(8'h35, 8'h4A, 3'd0, 1'b0, cyc, wr);
    check("add3_lat",   8'(cyc), 8'd9);
    check("add3_acc",   acc_m, 8'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
